channel_scan_mux: RTL

//  Parametrised successor to the fixed 3x8-bit RGB channel select.
//  - Holds a packed N_CH x CH_W word and drives one registered channel slice.
//  - Manual mode: the channel is picked by sel.
//  - Scan mode: the channel rotates automatically every SCAN_PERIOD cycles.
//  - Sits between the colour/data source and the 7-segment/LED display path.
//  - out_valid strobes every output update so downstream logic latches only fresh values.

---
 rtl/channel_scan_mux.sv | 127 ++++++++++++
 1 files changed

// File: rtl/channel_scan_mux.sv
// Registered N_CH x CH_W channel selector with manual and timed auto-scan modes.
// Feeds one held channel slice, its index and an update strobe to the display path.
module channel_scan_mux #(
    parameter int CH_W        = 8,
    parameter int N_CH        = 3,
    parameter int SCAN_PERIOD = 100_000_000,
    localparam int SEL_W      = (N_CH > 2) ? $clog2(N_CH) : 1,
    localparam int CNT_W      = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH*CH_W-1:0]   data_in,
    input  logic                   data_valid,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   mode,
    input  logic                   freeze,
    output logic [CH_W-1:0]        channel_out,
    output logic [SEL_W-1:0]       channel_idx,
    output logic                   out_valid
);

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [SEL_W-1:0]       r_idx;
    logic [SEL_W-1:0]       w_idx_next;
    logic [SEL_W-1:0]       w_idx_wrap;
    logic [N_CH*CH_W-1:0]   r_hold;
    logic [N_CH*CH_W-1:0]   w_word;
    logic [CH_W-1:0]        r_out;
    logic                   r_out_valid;
    logic                   w_tick;

    function automatic logic in_range(input logic [SEL_W-1:0] idx);
        return ({1'b0, idx} < (SEL_W+1)'(N_CH));
    endfunction

    // Out-of-range manual indices map to channel 0 when scanning starts.
    function automatic logic [SEL_W-1:0] clamp_idx(input logic [SEL_W-1:0] idx);
        return in_range(idx) ? idx : '0;
    endfunction

    function automatic logic [CH_W-1:0] pick(input logic [N_CH*CH_W-1:0] word,
                                             input logic [SEL_W-1:0]     idx);
        logic [CH_W-1:0] slice;
        slice = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == SEL_W'(k)) begin
                slice = word[k*CH_W +: CH_W];
            end
        end
        return slice;
    endfunction

    assign w_word     = data_valid ? data_in : r_hold;
    assign w_tick     = (r_cnt == CNT_W'(SCAN_PERIOD - 1));
    assign w_idx_wrap = (r_idx == SEL_W'(N_CH - 1)) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_MANUAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_MANUAL: if (mode)  w_state_next = ST_SCAN;
            ST_SCAN:   if (!mode) w_state_next = ST_MANUAL;
            default:   w_state_next = ST_MANUAL;
        endcase
    end

    // Leaving scan takes priority over a period tick in the same cycle.
    always_comb begin
        w_idx_next = r_idx;
        w_cnt_next = '0;
        case (r_state)
            ST_MANUAL: begin
                w_idx_next = mode ? clamp_idx(sel) : sel;
            end
            ST_SCAN: begin
                if (!mode) begin
                    w_idx_next = sel;
                end else if (freeze) begin
                    w_cnt_next = r_cnt;
                end else if (w_tick) begin
                    w_idx_next = w_idx_wrap;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_idx_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold      <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_hold      <= w_word;
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_out       <= pick(w_word, w_idx_next);
            r_out_valid <= data_valid | (w_idx_next != r_idx) | (w_state_next != r_state);
        end
    end

    assign channel_out = r_out;
    assign channel_idx = r_idx;
    assign out_valid   = r_out_valid;

endmodule
